// File: rtl/ws2812_decoder_if.sv
// ws2812_decoder_if: serial input and decoded outputs of the WS2812 decoder.
// The master side drives the serial line DataIn and observes the results; the
// slave side is the decoder itself.
// WordValid and FrameDone are valid-only strobes with no ready: each is high
// for exactly one clock, and a consumer that needs the value must capture it
// on that cycle.
interface ws2812_decoder_if;
  logic        DataIn;
  logic [23:0] Word;
  logic        WordValid;
  logic [11:0] WordCount;
  logic        FrameDone;
  logic        ErrFlag;

  modport master (
    output DataIn,
    input  Word,
    input  WordValid,
    input  WordCount,
    input  FrameDone,
    input  ErrFlag
  );

  modport slave (
    input  DataIn,
    output Word,
    output WordValid,
    output WordCount,
    output FrameDone,
    output ErrFlag
  );
endinterface

// File: rtl/ws2812_decoder.sv
// ws2812_decoder: decodes a WS2812 (GRB, MSB first) serial stream into 24-bit
// words by measuring each high pulse, and detects frame ends from a long low.
// A high pulse of N synchronized cycles decodes as 1 when N >= BIT_THRESH; a
// pulse of N >= MAX_HIGH is over-long. A frame ends after RESET_CYCLES
// consecutive low cycles, provided a falling edge happened since the last one.
// Optional macro WS2812_ERRCHK_EN: over-long pulses are dropped and set the
// sticky ErrFlag, as does a frame end with a partial word. Without it ErrFlag
// is tied low, over-long pulses decode as 1 and partial words vanish silently.
module ws2812_decoder #(
  parameter int CLK_HZ       = 100000000,
  parameter int BIT_THRESH   = 60,
  parameter int MAX_HIGH     = 150,
  parameter int RESET_CYCLES = 5000
) (
  input logic             clk,
  input logic             reset,
  ws2812_decoder_if.slave bus
);

  // CLK_HZ only documents the timing the other parameters were chosen for.
  if (CLK_HZ < 1) begin : g_bad_clk_hz
    $error("ws2812_decoder: CLK_HZ must be positive");
  end

  localparam logic [7:0]  BIT_THRESH_C = 8'(BIT_THRESH);
  localparam logic [7:0]  MAX_HIGH_C   = 8'(MAX_HIGH);
  localparam logic [12:0] RESET_C      = 13'(RESET_CYCLES);
  localparam logic [12:0] RESET_M1_C   = 13'(RESET_CYCLES - 1);

  // Synchronizer and edge-detect flops: s_q is S, sd_q is its delayed copy Sd.
  logic        sync1_q, s_q, sd_q;
  logic [7:0]  high_cnt_q, high_cnt_d;
  logic [12:0] low_cnt_q, low_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  // Only the first 23 bits of a word are held here; the 24th bit is merged
  // straight into Word on the falling edge that completes it.
  logic [22:0] shift_q, shift_d;
  logic [23:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic [11:0] word_count_q, word_count_d;
  logic        frame_done_q, frame_done_d;
  // Set by any falling edge; a frame end only reports when this is set.
  logic        armed_q, armed_d;

  logic        rise, fall, bit_val, commit, word_done, frame_end;
  logic [23:0] shifted;

`ifdef WS2812_ERRCHK_EN
  logic err_q, err_d;
  logic over_long;
`endif

  // Two-flop synchronizer followed by the one-cycle delay used for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      sync1_q <= bus.DataIn;
      s_q     <= sync1_q;
      sd_q    <= s_q;
    end
  end

  // Next-state logic: pulse measurement, bit commit, word and frame events.
  always_comb begin
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    word_count_d = word_count_q;
    frame_done_d = 1'b0;
    armed_d      = armed_q;
`ifdef WS2812_ERRCHK_EN
    err_d        = err_q;
`endif

    rise    = s_q & ~sd_q;
    fall    = ~s_q & sd_q;
    bit_val = (high_cnt_q >= BIT_THRESH_C);
    shifted = {shift_q, bit_val};

    // The rising-edge cycle is itself high, so a pulse of N high cycles
    // leaves HighCnt = N when its falling edge is seen.
    if (rise) begin
      high_cnt_d = 8'd1;
    end else if (s_q && (high_cnt_q < MAX_HIGH_C)) begin
      high_cnt_d = high_cnt_q + 8'd1;
    end

    if (s_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q < RESET_C) begin
      low_cnt_d = low_cnt_q + 13'd1;
    end

`ifdef WS2812_ERRCHK_EN
    over_long = fall && (high_cnt_q >= MAX_HIGH_C);
    commit    = fall && !over_long;
    if (over_long) begin
      err_d = 1'b1;
    end
`else
    commit = fall;
`endif

    word_done = commit && (bit_cnt_q == 5'd23);

    if (fall) begin
      armed_d = 1'b1;
    end

    if (commit) begin
      if (word_done) begin
        word_d       = shifted;
        word_valid_d = 1'b1;
        bit_cnt_d    = '0;
        shift_d      = '0;
      end else begin
        shift_d   = shifted[22:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    // WordCount keeps the frame total through the FrameDone cycle.
    if (frame_done_q) begin
      word_count_d = '0;
    end else if (word_done && (word_count_q != 12'hFFF)) begin
      word_count_d = word_count_q + 12'd1;
    end

    // LowCnt is about to reach RESET_CYCLES: the line has idled long enough.
    frame_end = ~s_q && (low_cnt_q == RESET_M1_C);
    if (frame_end) begin
      bit_cnt_d    = '0;
      shift_d      = '0;
      frame_done_d = armed_q;
      armed_d      = 1'b0;
`ifdef WS2812_ERRCHK_EN
      if (bit_cnt_q != 5'd0) begin
        err_d = 1'b1;
      end
`endif
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_count_q <= '0;
      frame_done_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      word_count_q <= word_count_d;
      frame_done_q <= frame_done_d;
      armed_q      <= armed_d;
    end
  end

`ifdef WS2812_ERRCHK_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.ErrFlag = err_q;
`else
  assign bus.ErrFlag = 1'b0;
`endif

  assign bus.Word      = word_q;
  assign bus.WordValid = word_valid_q;
  assign bus.WordCount = word_count_q;
  assign bus.FrameDone = frame_done_q;

endmodule

// File: doc/ws2812_decoder.md
WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency; documentation only, no logic depends on it.
REQ-002 Parameter BIT_THRESH, default 60, high-pulse length in cycles at or above which a bit decodes as 1.
REQ-003 Parameter MAX_HIGH, default 150, high-pulse length in cycles at or above which the pulse is invalid.
REQ-004 Parameter RESET_CYCLES, default 5000, continuous-low length in cycles that ends a frame (50 us at 100 MHz).
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 DataIn  input  1  asynchronous WS2812 serial line (GRB, MSB first).
REQ-008 Word  output  24  last complete decoded GRB word.
REQ-009 WordValid  output  1  one-cycle pulse when Word updates.
REQ-010 WordCount  output  12  words decoded in the current frame.
REQ-011 FrameDone  output  1  one-cycle pulse at frame end.
REQ-012 ErrFlag  output  1  sticky decode-error indicator.

Function
REQ-013 DataIn SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value S and its one-cycle-delayed copy Sd.
REQ-014 HighCnt (8 bits) SHALL count cycles with S=1, saturating at MAX_HIGH, and clear on every rising edge (S=1, Sd=0).
REQ-015 On a falling edge (S=0, Sd=1) with HighCnt < MAX_HIGH, the decoder SHALL shift bit (HighCnt >= BIT_THRESH) into the LSB of a 24-bit shift register and increment BitCnt (0..23).
REQ-016 On the falling edge that commits bit 24, Word SHALL load the full 24-bit value and WordValid SHALL assert on the next clock edge for exactly one cycle; BitCnt SHALL wrap to 0.
REQ-017 WordCount SHALL increment on the same edge that asserts WordValid and saturate at 4095.
REQ-018 LowCnt (13 bits) SHALL count cycles with S=0, clear whenever S=1, and saturate at RESET_CYCLES.
REQ-019 FrameDone SHALL pulse for one cycle on the edge where LowCnt reaches RESET_CYCLES, only if at least one falling edge has occurred since the previous FrameDone or since reset.
REQ-020 During the FrameDone cycle, WordCount SHALL still hold the frame's total; it SHALL clear to 0 on the following edge.
REQ-021 At frame end, BitCnt and the shift register SHALL clear; Word SHALL hold its last value.
REQ-022 A falling edge with HighCnt = MAX_HIGH (over-long pulse) SHALL NOT commit a bit.
REQ-023 Word SHALL change only with WordValid.
REQ-024 Idle high line: HighCnt saturates; no bits or frames are produced until a falling edge occurs.

Reset
REQ-025 While reset=1: Word=24'h000000, WordValid=0, WordCount=0, FrameDone=0, ErrFlag=0; synchronizer flops, HighCnt, LowCnt, BitCnt and the shift register are all 0.
REQ-026 Reset asserted mid-word SHALL discard all partial bits; the first bit after reset release starts a new word.

Configuration
REQ-027 Macro WS2812_ERRCHK_EN defined: ErrFlag SHALL set on an over-long pulse (REQ-022) or on a frame end with BitCnt != 0, and SHALL clear only on reset.
REQ-028 Macro WS2812_ERRCHK_EN undefined: ErrFlag is constant 0; an over-long pulse decodes as bit 1; a partial word at frame end is discarded silently.

Verification
REQ-029 Frame of word 0x0F0F0F (T0H=40, T1H=80, period 125 cycles) followed by 5000 low cycles -> WordValid pulses once with Word=0x0F0F0F; FrameDone pulses once with WordCount=1; WordCount=0 on the next cycle.
REQ-030 Frame of words 0xFF0000, 0x00FF00, 0x0000FF followed by a reset gap -> three WordValid pulses in order; WordCount=3 at FrameDone; ErrFlag=0.
REQ-031 10 valid bits, then 5000 low cycles -> no WordValid; FrameDone pulses; ErrFlag=1 with the macro, 0 without.
REQ-032 A 200-cycle high pulse inside a word -> with the macro, the bit is dropped and ErrFlag=1; without it, the pulse decodes as 1 and the word completes after 24 pulses.
REQ-033 reset asserted after 12 bits, released, then a full 0xA5A5A5 word is sent -> Word=0xA5A5A5 with no corruption from the earlier bits.
REQ-034 Gap of 4999 low cycles between two 24-bit words -> no FrameDone; WordCount=2; FrameDone fires only after 5000 consecutive low cycles.
